vm_param_ctrl: RTL and testbench
================================

# vm_param_ctrl

Parametrised vending-machine controller; the successor to the fixed-price nickel/dime/quarter FSM. It accumulates credit from single-cycle coin pulses and vends once credit reaches a configurable price. Change is returned as a serial burst of dime/nickel ejection pulses, one coin per cycle. It sits between the coin-acceptor front end and the product and coin-ejector solenoid drivers.

## Interface
- PRICE, 3: product price in nickels (5¢ units); legal range ≥1.
- CW, 4: credit register width; must satisfy 2^CW > PRICE+4.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- N  in  1  nickel inserted (5¢), one-cycle pulse.
- D  in  1  dime inserted (10¢), one-cycle pulse.
- Q  in  1  quarter inserted (25¢), one-cycle pulse.
- cancel  in  1  refund request, one-cycle pulse (used only with REFUND_EN).
- ready  out  1  high in COLLECT; coins are accepted only while high.
- dispense  out  1  one-cycle vend pulse.
- ret_nickel  out  1  eject one nickel this cycle.
- ret_dime  out  1  eject one dime this cycle.
- coin_err  out  1  one-cycle pulse when an illegal coin combination is sampled.
- credit  out  CW  current credit in nickels.
- PS  out  2  present state: COLLECT=00, DISPENSE=01, CHANGE=10, REFUND=11.

## Operation
- Reset values: PS=COLLECT, credit=0, ready=1, dispense=0, ret_nickel=0, ret_dime=0, coin_err=0.
- Coin values: N=1, D=2, Q=5 nickels.
- All outputs are Moore outputs decoded from PS, credit, and one registered coin_err flag.
- COLLECT:
  - A valid coin is exactly one of N/D/Q high while ready=1. It adds its value to credit.
  - If the new credit ≥ PRICE, next state is DISPENSE; otherwise stay in COLLECT.
  - Two or more of N/D/Q high in the same cycle: no credit change, and coin_err is high the next cycle.
  - Coins arriving while ready=0 are ignored. No coin_err is raised.
- DISPENSE (one cycle): dispense=1. Next credit = credit−PRICE. Next state is COLLECT if the result is 0, otherwise CHANGE.
- CHANGE (one cycle per coin):
  - If credit ≥ 2: ret_dime=1 and credit −= 2.
  - Otherwise: ret_nickel=1 and credit −= 1.
  - When credit reaches 0, next state is COLLECT.
- Change therefore always uses the most dimes and at most one nickel.
- Arithmetic is unsigned. Credit can never exceed PRICE+4, so there is no overflow path.

## Timing
- Coin sampled at edge t → credit visible at t+1.
- Vend latency: DISPENSE occupies cycle t+1. Change pulses start at t+2, one coin per cycle, then ready returns.
- Total ready=0 duration = 1 + number of change coins.
- Reset during DISPENSE, CHANGE or REFUND aborts immediately. Pending change or refund is discarded and all outputs take reset values on the next cycle.
- Reset has priority over every input in the same cycle.

## Configuration
- REFUND_EN defined:
  - cancel in COLLECT with credit > 0 → REFUND.
  - A valid coin in the same cycle as cancel is added to credit first and is included in the refund.
  - REFUND ejects coins exactly like CHANGE (dime-first, one per cycle) with no dispense pulse, then returns to COLLECT with credit=0.
  - cancel with credit = 0 and no coin is ignored.
- REFUND_EN undefined: cancel is ignored, REFUND state is unreachable, and PS never equals 11.

## Test plan
- PRICE=3, reset then Q → DISPENSE with credit=5, one ret_dime, COLLECT with credit=0; ready low for exactly 2 cycles.
- PRICE=3, D then Q → credit 2 then 7; dispense; ret_dime on two consecutive cycles; credit returns to 0.
- PRICE=3, N, N, N → credit 1, 2, 3; dispense with no change pulses; back to COLLECT the following cycle.
- N and D high in the same cycle → credit unchanged, coin_err=1 for one cycle. Also: a Q during CHANGE is ignored and credit is unaffected.
- REFUND_EN, PRICE=5, N then cancel+D → credit 3, REFUND: ret_dime then ret_nickel, no dispense. Without REFUND_EN, the same stimulus leaves credit at 3 in COLLECT.
- Assert reset during the second change cycle of the D-then-Q case → next cycle PS=00, credit=0, and no further ret pulses.

Source files
------------

// File: rtl/vm_param_ctrl_if.sv
// Coin-acceptor / ejector bus between the front end and vm_param_ctrl.
// master drives coin and cancel pulses; slave is the controller.
interface vm_param_ctrl_if #(
    parameter int unsigned CW = 4
);
    logic          N;
    logic          D;
    logic          Q;
    logic          cancel;
    logic          ready;
    logic          dispense;
    logic          ret_nickel;
    logic          ret_dime;
    logic          coin_err;
    logic [CW-1:0] credit;
    logic [1:0]    PS;

    modport master (
        output N, D, Q, cancel,
        input  ready, dispense, ret_nickel, ret_dime, coin_err, credit, PS
    );

    modport slave (
        input  N, D, Q, cancel,
        output ready, dispense, ret_nickel, ret_dime, coin_err, credit, PS
    );
endinterface

// File: rtl/vm_param_ctrl.sv
// Parametrised vending-machine controller: credit accumulation, vend, dime-first change.
// Optional cancel/refund path enabled by defining REFUND_EN.
module vm_param_ctrl #(
    parameter int unsigned PRICE = 3,
    parameter int unsigned CW    = 4
) (
    input  logic           clk,
    input  logic           reset,
    vm_param_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        COLLECT  = 2'b00,
        DISPENSE = 2'b01,
        CHANGE   = 2'b10,
        REFUND   = 2'b11
    } state_e;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          coin_err_q, coin_err_d;

    logic [CW-1:0] coin_val;
    logic          coin_multi;
    logic [CW-1:0] credit_sum;
    logic [CW-1:0] credit_after_vend;
    logic [CW-1:0] credit_after_eject;
    logic          cancel_req;

    // Decode the coin pulses; more than one at once is a sensing error
    always_comb begin
        coin_val   = '0;
        coin_multi = 1'b0;
        case ({bus.N, bus.D, bus.Q})
            3'b000:  coin_val = '0;
            3'b100:  coin_val = CW'(1);
            3'b010:  coin_val = CW'(2);
            3'b001:  coin_val = CW'(5);
            default: coin_multi = 1'b1;
        endcase
    end

    assign credit_sum         = credit_q + coin_val;
    assign credit_after_vend  = credit_q - PRICE_C;
    assign credit_after_eject = (credit_q >= CW'(2)) ? (credit_q - CW'(2))
                                                     : (credit_q - CW'(1));

`ifdef REFUND_EN
    assign cancel_req = bus.cancel;
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign cancel_req    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            coin_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_err_q <= coin_err_d;
        end
    end

    // Next-state logic; coins only count in COLLECT, where ready is high
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_err_d = 1'b0;
        unique case (state_q)
            COLLECT: begin
                coin_err_d = coin_multi;
                credit_d   = credit_sum;
                // Cancel outranks vend so a coin arriving with cancel is refunded
                if (cancel_req && (credit_sum != '0)) begin
                    state_d = REFUND;
                end else if (credit_sum >= PRICE_C) begin
                    state_d = DISPENSE;
                end
            end
            DISPENSE: begin
                credit_d = credit_after_vend;
                state_d  = (credit_after_vend == '0) ? COLLECT : CHANGE;
            end
            CHANGE, REFUND: begin
                credit_d = credit_after_eject;
                if (credit_after_eject == '0) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state and credit registers
    always_comb begin
        bus.ready      = (state_q == COLLECT);
        bus.dispense   = (state_q == DISPENSE);
        bus.ret_dime   = ((state_q == CHANGE) || (state_q == REFUND)) && (credit_q >= CW'(2));
        bus.ret_nickel = ((state_q == CHANGE) || (state_q == REFUND)) && (credit_q == CW'(1));
        bus.coin_err   = coin_err_q;
        bus.credit     = credit_q;
        bus.PS         = state_q;
    end
endmodule

// File: tb/tb_vm_param_ctrl.sv
// Directed bench for vm_param_ctrl: PRICE=3 unit for vend/change/reset, PRICE=5 unit for cancel.
module tb_vm_param_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    vm_param_ctrl_if #(.CW(4)) bus_a ();
    vm_param_ctrl_if #(.CW(4)) bus_b ();

    vm_param_ctrl #(.PRICE(3), .CW(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    vm_param_ctrl #(.PRICE(5), .CW(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus_a.N = 0; bus_a.D = 0; bus_a.Q = 0; bus_a.cancel = 0;
        bus_b.N = 0; bus_b.D = 0; bus_b.Q = 0; bus_b.cancel = 0;
        reset = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_ps",       32'(bus_a.PS), 0);
        chk("rst_credit",   32'(bus_a.credit), 0);
        chk("rst_ready",    32'(bus_a.ready), 1);
        chk("rst_dispense", 32'(bus_a.dispense), 0);
        chk("rst_ret_n",    32'(bus_a.ret_nickel), 0);
        chk("rst_ret_d",    32'(bus_a.ret_dime), 0);
        chk("rst_coin_err", 32'(bus_a.coin_err), 0);

        // Reset wins over a coin in the same cycle
        bus_a.Q = 1; tick(); bus_a.Q = 0;
        chk("rst_prio_credit", 32'(bus_a.credit), 0);
        chk("rst_prio_ps",     32'(bus_a.PS), 0);
        reset = 1'b0;

        // Q at PRICE=3: vend, one dime, ready low 2 cycles
        bus_a.Q = 1; tick(); bus_a.Q = 0;
        chk("q_disp_ps",     32'(bus_a.PS), 1);
        chk("q_disp_credit", 32'(bus_a.credit), 5);
        chk("q_disp_pulse",  32'(bus_a.dispense), 1);
        chk("q_disp_ready",  32'(bus_a.ready), 0);
        tick();
        chk("q_chg_ps",     32'(bus_a.PS), 2);
        chk("q_chg_credit", 32'(bus_a.credit), 2);
        chk("q_chg_dime",   32'(bus_a.ret_dime), 1);
        chk("q_chg_nickel", 32'(bus_a.ret_nickel), 0);
        chk("q_chg_ready",  32'(bus_a.ready), 0);
        tick();
        chk("q_end_ps",     32'(bus_a.PS), 0);
        chk("q_end_credit", 32'(bus_a.credit), 0);
        chk("q_end_ready",  32'(bus_a.ready), 1);
        chk("q_end_dime",   32'(bus_a.ret_dime), 0);

        // D then Q: credit 2, 7, two dimes; a Q during CHANGE is ignored
        bus_a.D = 1; tick(); bus_a.D = 0;
        chk("dq_credit2", 32'(bus_a.credit), 2);
        chk("dq_ps0",     32'(bus_a.PS), 0);
        bus_a.Q = 1; tick(); bus_a.Q = 0;
        chk("dq_credit7", 32'(bus_a.credit), 7);
        chk("dq_disp",    32'(bus_a.dispense), 1);
        tick();
        chk("dq_chg1_credit", 32'(bus_a.credit), 4);
        chk("dq_chg1_dime",   32'(bus_a.ret_dime), 1);
        bus_a.Q = 1; tick(); bus_a.Q = 0;
        chk("dq_chg2_credit", 32'(bus_a.credit), 2);
        chk("dq_chg2_dime",   32'(bus_a.ret_dime), 1);
        chk("dq_chg2_ps",     32'(bus_a.PS), 2);
        chk("dq_chg2_err",    32'(bus_a.coin_err), 0);
        tick();
        chk("dq_end_ps",     32'(bus_a.PS), 0);
        chk("dq_end_credit", 32'(bus_a.credit), 0);
        chk("dq_end_dime",   32'(bus_a.ret_dime), 0);

        // N, N, N: exact price, no change
        bus_a.N = 1; tick();
        chk("nnn_c1", 32'(bus_a.credit), 1);
        tick();
        chk("nnn_c2", 32'(bus_a.credit), 2);
        tick(); bus_a.N = 0;
        chk("nnn_c3",   32'(bus_a.credit), 3);
        chk("nnn_disp", 32'(bus_a.dispense), 1);
        chk("nnn_ps1",  32'(bus_a.PS), 1);
        tick();
        chk("nnn_end_ps",     32'(bus_a.PS), 0);
        chk("nnn_end_credit", 32'(bus_a.credit), 0);
        chk("nnn_end_dime",   32'(bus_a.ret_dime), 0);
        chk("nnn_end_nickel", 32'(bus_a.ret_nickel), 0);

        // N+D together: no credit, one-cycle coin_err
        bus_a.N = 1; bus_a.D = 1; tick(); bus_a.N = 0; bus_a.D = 0;
        chk("multi_credit", 32'(bus_a.credit), 0);
        chk("multi_err",    32'(bus_a.coin_err), 1);
        chk("multi_ps",     32'(bus_a.PS), 0);
        tick();
        chk("multi_err_clr", 32'(bus_a.coin_err), 0);

        // PRICE=5 unit: N then cancel+D
        bus_b.N = 1; tick(); bus_b.N = 0;
        chk("can_c1", 32'(bus_b.credit), 1);
        bus_b.cancel = 1; bus_b.D = 1; tick(); bus_b.cancel = 0; bus_b.D = 0;
        chk("can_c3", 32'(bus_b.credit), 3);
`ifdef REFUND_EN
        chk("ref_ps",     32'(bus_b.PS), 3);
        chk("ref_dime",   32'(bus_b.ret_dime), 1);
        chk("ref_nickel", 32'(bus_b.ret_nickel), 0);
        chk("ref_disp",   32'(bus_b.dispense), 0);
        chk("ref_ready",  32'(bus_b.ready), 0);
        tick();
        chk("ref2_credit", 32'(bus_b.credit), 1);
        chk("ref2_nickel", 32'(bus_b.ret_nickel), 1);
        chk("ref2_dime",   32'(bus_b.ret_dime), 0);
        chk("ref2_disp",   32'(bus_b.dispense), 0);
        tick();
        chk("ref_end_ps",     32'(bus_b.PS), 0);
        chk("ref_end_credit", 32'(bus_b.credit), 0);
        chk("ref_end_nickel", 32'(bus_b.ret_nickel), 0);
        bus_b.cancel = 1; tick(); bus_b.cancel = 0;
        chk("can_zero_ps",     32'(bus_b.PS), 0);
        chk("can_zero_credit", 32'(bus_b.credit), 0);
`else
        chk("noref_ps", 32'(bus_b.PS), 0);
        tick();
        chk("noref_ps2",     32'(bus_b.PS), 0);
        chk("noref_credit2", 32'(bus_b.credit), 3);
        chk("noref_dime",    32'(bus_b.ret_dime), 0);
`endif

        // Reset during the second change cycle of D-then-Q
        bus_a.D = 1; tick(); bus_a.D = 0;
        bus_a.Q = 1; tick(); bus_a.Q = 0;
        tick();
        tick();
        chk("abort_pre_credit", 32'(bus_a.credit), 2);
        chk("abort_pre_ps",     32'(bus_a.PS), 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_ps",     32'(bus_a.PS), 0);
        chk("abort_credit", 32'(bus_a.credit), 0);
        chk("abort_dime",   32'(bus_a.ret_dime), 0);
        chk("abort_ready",  32'(bus_a.ready), 1);
        tick();
        chk("abort_post_dime",   32'(bus_a.ret_dime), 0);
        chk("abort_post_nickel", 32'(bus_a.ret_nickel), 0);
        chk("abort_post_credit", 32'(bus_a.credit), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
